dmem_port_arbiter: RTL and testbench

- Sequences and shares the 64-bit-word data memory between two requesters: port 0 (core load/store unit) and port 1 (program loader/debug).
- Round-robin arbitration; byte-address to word-address translation.
- Sub-word loads with sign/zero extension.
- Byte/half/word stores via read-modify-write (RMW) on the word-wide memory.
- Sits between the requesters and the memory's mem_read/mem_write/rd_addr/wr_addr/data_in/data_out interface.

---
 rtl/dmem_port_arbiter.sv | 246 ++++++++++++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter in front of a word-wide (64-bit) data memory.
// Round-robin grant between port 0 (load/store unit) and port 1 (loader/debug),
// byte-to-word address translation, sign/zero-extended sub-word loads and
// read-modify-write sub-word stores.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   reqX/weX/sizeX/unsX      per-port request, store flag, size, unsigned-load flag
//   addrX/wdataX             per-port byte address and right-aligned store data
//   ackX/errX/rdataX         per-port completion pulse, misalignment flag, load data
//   busy                     high whenever the sequencer is not idle
//   mem_read/mem_write       memory enables (never both high)
//   rd_addr/wr_addr/data_in  memory word addresses and write data
//   mem_data_out             combinational memory read data
module dmem_port_arbiter #(
  parameter int unsigned ADDRESS_SIZE = 10,
  parameter int unsigned N            = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req0,
  input  logic                      we0,
  input  logic [1:0]                size0,
  input  logic                      uns0,
  input  logic [ADDRESS_SIZE+2:0]   addr0,
  input  logic [N-1:0]              wdata0,
  output logic                      ack0,
  output logic                      err0,
  output logic [N-1:0]              rdata0,
  input  logic                      req1,
  input  logic                      we1,
  input  logic [1:0]                size1,
  input  logic                      uns1,
  input  logic [ADDRESS_SIZE+2:0]   addr1,
  input  logic [N-1:0]              wdata1,
  output logic                      ack1,
  output logic                      err1,
  output logic [N-1:0]              rdata1,
  output logic                      busy,
  output logic                      mem_read,
  output logic                      mem_write,
  output logic [ADDRESS_SIZE-1:0]   rd_addr,
  output logic [ADDRESS_SIZE-1:0]   wr_addr,
  output logic [N-1:0]              data_in,
  input  logic [N-1:0]              mem_data_out
);

  localparam int unsigned AW = ADDRESS_SIZE + 3;

  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, DONE} state_t;

  state_t                  state_q, state_d;
  logic                    last_grant_q, last_grant_d;
  logic                    port_q, port_d;
  logic                    we_q, we_d;
  logic                    uns_q, uns_d;
  logic [1:0]              size_q, size_d;
  logic [AW-1:0]           addr_q, addr_d;
  logic [N-1:0]            wdata_q, wdata_d;
  logic                    ack0_d, ack1_d, err0_d, err1_d, busy_d;
  logic [N-1:0]            rdata0_d, rdata1_d, data_in_d;
  logic                    mem_read_d, mem_write_d;
  logic [ADDRESS_SIZE-1:0] rd_addr_d, wr_addr_d;

  logic                    g_port, g_we, g_uns;
  logic [1:0]              g_size;
  logic [AW-1:0]           g_addr;
  logic [N-1:0]            g_wdata;
  logic                    fin, fin_err;
  logic [N-1:0]            fin_data;

  logic [5:0]              sh;
  logic [N-1:0]            field, fmask, load_val, merged;

  function automatic logic misaligned(input logic [1:0] sz, input logic [2:0] off);
    case (sz)
      2'd1:    misaligned = off[0];
      2'd2:    misaligned = |off[1:0];
      2'd3:    misaligned = |off;
      default: misaligned = 1'b0;
    endcase
  endfunction

  // Little-endian field extraction and store merge for the latched request
  always_comb begin
    sh    = {addr_q[2:0], 3'b000};
    field = mem_data_out >> sh;
    case (size_q)
      2'd0:    fmask = N'(8'hFF);
      2'd1:    fmask = N'(16'hFFFF);
      2'd2:    fmask = N'(32'hFFFF_FFFF);
      default: fmask = '1;
    endcase
    case (size_q)
      2'd0:    load_val = uns_q ? N'(field[7:0])  : {{(N-8){field[7]}},   field[7:0]};
      2'd1:    load_val = uns_q ? N'(field[15:0]) : {{(N-16){field[15]}}, field[15:0]};
      2'd2:    load_val = uns_q ? N'(field[31:0]) : {{(N-32){field[31]}}, field[31:0]};
      default: load_val = field;
    endcase
    merged = (mem_data_out & ~(fmask << sh)) | ((wdata_q & fmask) << sh);
  end

  // Next-state and registered-output logic; memory strobes are decided one
  // cycle ahead so they come straight out of flops in the state that uses them
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    port_d       = port_q;
    we_d         = we_q;
    uns_d        = uns_q;
    size_d       = size_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    err0_d       = err0;
    err1_d       = err1;
    rdata0_d     = rdata0;
    rdata1_d     = rdata1;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    rd_addr_d    = rd_addr;
    wr_addr_d    = wr_addr;
    data_in_d    = data_in;
    fin          = 1'b0;
    fin_err      = 1'b0;
    fin_data     = '0;

    // Port 0 wins unless port 1 also requests and port 0 was granted last
    g_port  = ~(req0 & (~req1 | last_grant_q));
    g_we    = g_port ? we1    : we0;
    g_uns   = g_port ? uns1   : uns0;
    g_size  = g_port ? size1  : size0;
    g_addr  = g_port ? addr1  : addr0;
    g_wdata = g_port ? wdata1 : wdata0;

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          port_d       = g_port;
          last_grant_d = g_port;
          we_d         = g_we;
          uns_d        = g_uns;
          size_d       = g_size;
          addr_d       = g_addr;
          wdata_d      = g_wdata;
          state_d      = ACCESS;
          if (!misaligned(g_size, g_addr[2:0])) begin
            if (g_we && g_size == 2'd3) begin
              mem_write_d = 1'b1;
              wr_addr_d   = g_addr[AW-1:3];
              data_in_d   = g_wdata;
            end else begin
              mem_read_d  = 1'b1;
              rd_addr_d   = g_addr[AW-1:3];
            end
          end
        end
      end
      ACCESS: begin
        if (misaligned(size_q, addr_q[2:0])) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end else if (!we_q) begin
          fin      = 1'b1;
          fin_data = load_val;
        end else if (size_q == 2'd3) begin
          fin = 1'b1;
        end else begin
          mem_write_d = 1'b1;
          wr_addr_d   = addr_q[AW-1:3];
          data_in_d   = merged;
          state_d     = WRITE;
        end
        if (fin) state_d = DONE;
      end
      WRITE: begin
        fin     = 1'b1;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (fin) begin
      if (port_q) begin
        ack1_d   = 1'b1;
        err1_d   = fin_err;
        rdata1_d = fin_data;
      end else begin
        ack0_d   = 1'b1;
        err0_d   = fin_err;
        rdata0_d = fin_data;
      end
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      port_q       <= 1'b0;
      we_q         <= 1'b0;
      uns_q        <= 1'b0;
      size_q       <= 2'd0;
      addr_q       <= '0;
      wdata_q      <= '0;
      ack0         <= 1'b0;
      ack1         <= 1'b0;
      err0         <= 1'b0;
      err1         <= 1'b0;
      rdata0       <= '0;
      rdata1       <= '0;
      busy         <= 1'b0;
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      rd_addr      <= '0;
      wr_addr      <= '0;
      data_in      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      port_q       <= port_d;
      we_q         <= we_d;
      uns_q        <= uns_d;
      size_q       <= size_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      ack0         <= ack0_d;
      ack1         <= ack1_d;
      err0         <= err0_d;
      err1         <= err1_d;
      rdata0       <= rdata0_d;
      rdata1       <= rdata1_d;
      busy         <= busy_d;
      mem_read     <= mem_read_d;
      mem_write    <= mem_write_d;
      rd_addr      <= rd_addr_d;
      wr_addr      <= wr_addr_d;
      data_in      <= data_in_d;
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, we0, uns0, req1, we1, uns1;
  logic [1:0]  size0, size1;
  logic [12:0] addr0, addr1;
  logic [63:0] wdata0, wdata1;
  logic        ack0, err0, ack1, err1, busy, mem_read, mem_write;
  logic [63:0] rdata0, rdata1, data_in, mem_data_out;
  logic [9:0]  rd_addr, wr_addr;

  logic [63:0] mem [0:1023];

  typedef struct {
    int          port;
    logic        err;
    logic [63:0] data;
    int          lat;
    int          issue;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rd_cnt = 0;
  int   wr_cnt = 0;
  logic [9:0] last_wr = '0;

  dmem_port_arbiter #(.ADDRESS_SIZE(10), .N(64)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .size0(size0), .uns0(uns0), .addr0(addr0), .wdata0(wdata0),
    .ack0(ack0), .err0(err0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .size1(size1), .uns1(uns1), .addr1(addr1), .wdata1(wdata1),
    .ack1(ack1), .err1(err1), .rdata1(rdata1),
    .busy(busy), .mem_read(mem_read), .mem_write(mem_write),
    .rd_addr(rd_addr), .wr_addr(wr_addr), .data_in(data_in),
    .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  // Behavioural word memory with combinational read
  assign mem_data_out = mem[rd_addr];
  always @(posedge clk) if (mem_write) mem[wr_addr] <= data_in;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: memory activity bookkeeping and scoreboard comparison on every ack
  initial forever begin
    exp_t x;
    @(negedge clk);
    if (mem_read) rd_cnt++;
    if (mem_write) begin
      wr_cnt++;
      last_wr = wr_addr;
    end
    if (mem_read && mem_write) chk("rd_wr_exclusive", 64'(1), 64'(0));
    if (ack0 && ack1) chk("single_ack", 64'(1), 64'(0));
    if (ack0 || ack1) begin
      if (q.size() == 0) begin
        chk("unexpected_ack", 64'({ack1, ack0}), 64'(0));
      end else begin
        x = q.pop_front();
        chk("ack_port", 64'(ack1), 64'(x.port));
        chk("ack_err", 64'(ack1 ? err1 : err0), 64'(x.err));
        chk("ack_rdata", ack1 ? rdata1 : rdata0, x.data);
        if (x.lat >= 0) chk("ack_latency", 64'(cyc - x.issue), 64'(x.lat));
      end
    end
  end

  task automatic drive(input int p, input logic we, input logic [1:0] sz, input logic uns,
                       input logic [12:0] a, input logic [63:0] wd);
    if (p == 0) begin
      req0 = 1'b1; we0 = we; size0 = sz; uns0 = uns; addr0 = a; wdata0 = wd;
    end else begin
      req1 = 1'b1; we1 = we; size1 = sz; uns1 = uns; addr1 = a; wdata1 = wd;
    end
  endtask

  // One access: push expectation, raise request, wait (bounded) for ack, drop request
  task automatic do_req(input int p, input logic we, input logic [1:0] sz, input logic uns,
                        input logic [12:0] a, input logic [63:0] wd,
                        input logic e_err, input logic [63:0] e_data, input int lat);
    exp_t x;
    bit   got;
    @(negedge clk);
    x.port = p; x.err = e_err; x.data = e_data; x.lat = lat; x.issue = cyc;
    q.push_back(x);
    drive(p, we, sz, uns, a, wd);
    got = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      @(negedge clk);
      if ((p == 0 && ack0) || (p == 1 && ack1)) got = 1'b1;
    end
    req0 = 1'b0;
    req1 = 1'b0;
    if (!got) begin
      chk("ack_timeout", 64'(0), 64'(1));
      if (q.size() > 0) void'(q.pop_back());
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ctrl", 64'({ack0, ack1, err0, err1, busy, mem_read, mem_write}), 64'(0));
    chk("rst_rdata0", rdata0, 64'(0));
    chk("rst_rdata1", rdata1, 64'(0));
    chk("rst_addrs", 64'({rd_addr, wr_addr}), 64'(0));
    chk("rst_data_in", data_in, 64'(0));
    rst = 1'b1;
  endtask

  initial begin
    int rd0, wr0, acks, busy_low;
    bit hit;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    req0 = 0; we0 = 0; size0 = 0; uns0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; size1 = 0; uns1 = 0; addr1 = 0; wdata1 = 0;
    do_reset();

    // dword store then dword load
    wr0 = wr_cnt;
    do_req(0, 1, 2'd3, 0, 13'h010, 64'h1122334455667788, 0, 64'h0, 2);
    chk("dword_store_writes", 64'(wr_cnt - wr0), 64'(1));
    chk("dword_store_wr_addr", 64'(last_wr), 64'(2));
    do_req(0, 0, 2'd3, 0, 13'h010, 64'h0, 0, 64'h1122334455667788, 2);

    // byte store via read-modify-write
    wr0 = wr_cnt;
    rd0 = rd_cnt;
    do_req(1, 1, 2'd0, 0, 13'h013, 64'hAB, 0, 64'h0, 3);
    chk("byte_store_reads", 64'(rd_cnt - rd0), 64'(1));
    chk("byte_store_writes", 64'(wr_cnt - wr0), 64'(1));
    chk("byte_store_word", mem[2], 64'h11223344AB667788);

    // sub-word loads
    do_req(0, 0, 2'd0, 0, 13'h013, 64'h0, 0, 64'hFFFFFFFFFFFFFFAB, 2);
    do_req(0, 0, 2'd0, 1, 13'h013, 64'h0, 0, 64'h00000000000000AB, 2);
    do_req(1, 0, 2'd1, 0, 13'h016, 64'h0, 0, 64'h0000000000001122, 2);

    // word store / signed word load; half store into the top word
    do_req(0, 1, 2'd2, 0, 13'h018, 64'h0000000080000001, 0, 64'h0, 3);
    do_req(0, 0, 2'd2, 0, 13'h018, 64'h0, 0, 64'hFFFFFFFF80000001, 2);
    do_req(1, 1, 2'd1, 0, 13'h1FFE, 64'hFFFFFFFF1234BEEF, 0, 64'h0, 3);
    do_req(1, 0, 2'd3, 0, 13'h1FF8, 64'h0, 0, 64'hBEEF000000000000, 2);

    // misaligned accesses touch no memory
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    do_req(1, 0, 2'd2, 0, 13'h012, 64'h0, 1, 64'h0, 2);
    do_req(0, 1, 2'd1, 0, 13'h011, 64'hFFFF, 1, 64'h0, 2);
    chk("misaligned_no_mem", 64'({rd_cnt - rd0, wr_cnt - wr0}), 64'(0));
    chk("misaligned_word_intact", mem[2], 64'h11223344AB667788);

    // fairness from reset with both requests held
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      exp_t x;
      x.port  = i % 2;
      x.err   = 1'b0;
      x.data  = (i % 2 == 0) ? 64'h11223344AB667788 : 64'h00000000000000AB;
      x.lat   = -1;
      x.issue = 0;
      q.push_back(x);
    end
    drive(0, 0, 2'd3, 0, 13'h010, 64'h0);
    drive(1, 0, 2'd0, 1, 13'h013, 64'h0);
    acks = 0;
    busy_low = 0;
    for (int i = 0; i < 40 && acks < 4; i++) begin
      @(negedge clk);
      if (ack0 || ack1) acks++;
      if (!busy) busy_low++;
    end
    req0 = 1'b0;
    req1 = 1'b0;
    chk("fair_acks", 64'(acks), 64'(4));
    chk("fair_busy_gaps", 64'(busy_low), 64'(3));

    // reset asserted while the RMW write is pending
    @(negedge clk);
    drive(0, 1, 2'd0, 0, 13'h010, 64'h55);
    hit = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin
      @(negedge clk);
      if (mem_write) hit = 1'b1;
    end
    chk("rmw_reached_write", 64'(hit), 64'(1));
    rst = 1'b0;
    req0 = 1'b0;
    #1;
    chk("midrst_ctrl", 64'({ack0, ack1, err0, err1, busy, mem_read, mem_write}), 64'(0));
    chk("midrst_data", data_in | rdata0 | rdata1, 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_word_intact", mem[2], 64'h11223344AB667788);
    chk("midrst_idle", 64'({busy, ack0, ack1}), 64'(0));
    chk("queue_empty", 64'(q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
